// File: rtl/mfp_irq_ctrl.sv
// MFP68901 interrupt controller: 16-source edge latch, enable/mask/in-service priority, IRQ_N and vectoring.
// Optional software end-of-interrupt (S mode, ISR registers) is built only when MFP_IRQ_SEI_EN is defined.
module mfp_irq_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IRQ_IN,
    input  logic [3:0]  ADDR,
    input  logic        WE,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    input  logic        IACK,
    output logic        IRQ_N,
    output logic [7:0]  VEC_O,
    output logic        VEC_VALID
);
    localparam logic [3:0] A_IERA = 4'd0;
    localparam logic [3:0] A_IERB = 4'd1;
    localparam logic [3:0] A_IPRA = 4'd2;
    localparam logic [3:0] A_IPRB = 4'd3;
    localparam logic [3:0] A_ISRA = 4'd4;
    localparam logic [3:0] A_ISRB = 4'd5;
    localparam logic [3:0] A_IMRA = 4'd6;
    localparam logic [3:0] A_IMRB = 4'd7;
    localparam logic [3:0] A_VR   = 4'd8;

    logic [15:0] in_q;
    logic [15:0] ier_q, ier_d;
    logic [15:0] ipr_q, ipr_d;
    logic [15:0] imr_q, imr_d;
    logic [15:0] isr;
    logic [7:0]  vr_q, vr_d;
    logic [7:0]  vec_q, vec_d;
    logic        irq_n_q, vld_q;
    logic [15:0] edge_s, qual;
    logic [3:0]  tgt;
    logic        hit, acc, ack;

    assign edge_s = IRQ_IN & ~in_q;
    assign qual   = ipr_q & imr_q;

    // Scan from the top: a channel qualifies only while no ISR bit at or above it has been seen.
    always_comb begin
        hit = 1'b0;
        tgt = 4'd0;
        acc = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            acc = acc | isr[i];
            if (!hit && qual[i] && !acc) begin
                hit = 1'b1;
                tgt = 4'(i);
            end
        end
    end

    // An acknowledge is honoured only if something still qualifies at the IACK edge.
    assign ack = IACK & ~irq_n_q & hit;

    always_comb begin
        ier_d = ier_q;
        imr_d = imr_q;
        ipr_d = ipr_q;
        vr_d  = vr_q;
        if (WE) begin
            case (ADDR)
                A_IERA: ier_d[15:8] = DAT_I;
                A_IERB: ier_d[7:0]  = DAT_I;
                A_IPRA: ipr_d[15:8] = ipr_q[15:8] & DAT_I;
                A_IPRB: ipr_d[7:0]  = ipr_q[7:0] & DAT_I;
                A_IMRA: imr_d[15:8] = DAT_I;
                A_IMRB: imr_d[7:0]  = DAT_I;
`ifdef MFP_IRQ_SEI_EN
                A_VR:   vr_d = DAT_I;
`else
                A_VR:   vr_d = {DAT_I[7:4], 1'b0, DAT_I[2:0]};
`endif
                default: ;
            endcase
        end
        ipr_d = ipr_d & ier_d;
        if (ack)
            ipr_d[tgt] = 1'b0;
        // New edges are applied last so they win over any clear in the same cycle.
        ipr_d = ipr_d | (edge_s & ier_d);
        vec_d = ack ? {vr_q[7:4], tgt} : vec_q;
    end

`ifdef MFP_IRQ_SEI_EN
    logic [15:0] isr_q, isr_d;

    always_comb begin
        isr_d = isr_q;
        if (WE && ADDR == A_ISRA)
            isr_d[15:8] = isr_q[15:8] & DAT_I;
        if (WE && ADDR == A_ISRB)
            isr_d[7:0] = isr_q[7:0] & DAT_I;
        if (ack && vr_q[3])
            isr_d[tgt] = 1'b1;
        if (WE && ADDR == A_VR && !DAT_I[3])
            isr_d = 16'h0000;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            isr_q <= 16'h0000;
        else
            isr_q <= isr_d;
    end

    assign isr = isr_q;
`else
    assign isr = 16'h0000;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_q    <= 16'h0000;
            ier_q   <= 16'h0000;
            ipr_q   <= 16'h0000;
            imr_q   <= 16'h0000;
            vr_q    <= 8'h00;
            vec_q   <= 8'h00;
            irq_n_q <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            in_q    <= IRQ_IN;
            ier_q   <= ier_d;
            ipr_q   <= ipr_d;
            imr_q   <= imr_d;
            vr_q    <= vr_d;
            vec_q   <= vec_d;
            irq_n_q <= ~hit;
            vld_q   <= ack;
        end
    end

    always_comb begin
        DAT_O = 8'h00;
        case (ADDR)
            A_IERA: DAT_O = ier_q[15:8];
            A_IERB: DAT_O = ier_q[7:0];
            A_IPRA: DAT_O = ipr_q[15:8];
            A_IPRB: DAT_O = ipr_q[7:0];
            A_ISRA: DAT_O = isr[15:8];
            A_ISRB: DAT_O = isr[7:0];
            A_IMRA: DAT_O = imr_q[15:8];
            A_IMRB: DAT_O = imr_q[7:0];
            A_VR:   DAT_O = vr_q;
            default: DAT_O = 8'h00;
        endcase
    end

    assign IRQ_N     = irq_n_q;
    assign VEC_O     = vec_q;
    assign VEC_VALID = vld_q;
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Self-checking bench for mfp_irq_ctrl: directed scenarios plus a randomized run against a
// behavioural model. Follows MFP_IRQ_SEI_EN so the same bench covers both builds.
module tb_mfp_irq_ctrl;
`ifdef MFP_IRQ_SEI_EN
    localparam bit SEI = 1'b1;
`else
    localparam bit SEI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irq_in;
    logic [3:0]  addr;
    logic        we;
    logic [7:0]  dat_i;
    logic        iack;
    logic [7:0]  dat_o;
    logic        irq_n;
    logic [7:0]  vec_o;
    logic        vec_valid;

    int checks = 0;
    int errors = 0;

    mfp_irq_ctrl dut (
        .CLK(clk), .RST_N(rst_n), .IRQ_IN(irq_in), .ADDR(addr), .WE(we), .DAT_I(dat_i),
        .DAT_O(dat_o), .IACK(iack), .IRQ_N(irq_n), .VEC_O(vec_o), .VEC_VALID(vec_valid)
    );

    initial forever #5 clk = ~clk;

    // Behavioural model state and its next-state copies
    logic [15:0] m_in, m_ier, m_ipr, m_imr, m_isr;
    logic [7:0]  m_vr, m_vec;
    logic        m_irqn, m_vld;
    logic [15:0] n_in, n_ier, n_ipr, n_imr, n_isr;
    logic [7:0]  n_vr, n_vec;
    logic        n_irqn, n_vld;

    task automatic model_reset();
        m_in = 0; m_ier = 0; m_ipr = 0; m_imr = 0; m_isr = 0;
        m_vr = 0; m_vec = 0; m_irqn = 1'b1; m_vld = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return m_ier[15:8];
            4'd1: return m_ier[7:0];
            4'd2: return m_ipr[15:8];
            4'd3: return m_ipr[7:0];
            4'd4: return m_isr[15:8];
            4'd5: return m_isr[7:0];
            4'd6: return m_imr[15:8];
            4'd7: return m_imr[7:0];
            4'd8: return m_vr;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        int top, best;
        logic [15:0] e;
        logic ackm;
        e = irq_in & ~m_in;
        top = -1;
        for (int i = 0; i < 16; i++) if (m_isr[i]) top = i;
        best = -1;
        for (int i = 0; i < 16; i++) if (m_ipr[i] && m_imr[i] && i > top) best = i;
        ackm = iack && !m_irqn && best >= 0;
        n_ier = m_ier; n_ipr = m_ipr; n_imr = m_imr; n_isr = m_isr; n_vr = m_vr; n_vec = m_vec;
        n_vld = ackm;
        n_irqn = (best < 0);
        n_in = irq_in;
        if (we) begin
            case (addr)
                4'd0: n_ier[15:8] = dat_i;
                4'd1: n_ier[7:0] = dat_i;
                4'd2: n_ipr[15:8] = m_ipr[15:8] & dat_i;
                4'd3: n_ipr[7:0] = m_ipr[7:0] & dat_i;
                4'd4: if (SEI) n_isr[15:8] = m_isr[15:8] & dat_i;
                4'd5: if (SEI) n_isr[7:0] = m_isr[7:0] & dat_i;
                4'd6: n_imr[15:8] = dat_i;
                4'd7: n_imr[7:0] = dat_i;
                4'd8: n_vr = SEI ? dat_i : (dat_i & 8'hF7);
                default: ;
            endcase
            if (addr <= 4'd1) n_ipr = n_ipr & n_ier;
        end
        if (ackm) begin
            n_ipr[best] = 1'b0;
            if (SEI && m_vr[3]) n_isr[best] = 1'b1;
            n_vec = {m_vr[7:4], 4'(best)};
        end
        if (SEI && we && addr == 4'd8 && !dat_i[3]) n_isr = 16'h0000;
        n_ipr = n_ipr | (e & n_ier);
    endtask

    // One clock: model evaluates the same inputs the DUT samples, then both advance.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        m_in = n_in; m_ier = n_ier; m_ipr = n_ipr; m_imr = n_imr; m_isr = n_isr;
        m_vr = n_vr; m_vec = n_vec; m_irqn = n_irqn; m_vld = n_vld;
        we = 1'b0;
        iack = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr = a; dat_i = d; we = 1'b1;
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = 0; addr = 0; we = 0; dat_i = 0; iack = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_irqn got %b exp 1", irq_n); end
        checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", vec_valid); end
        checks++; if (vec_o !== 8'h00) begin errors++; $display("FAIL rst_vec got %h exp 00", vec_o); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #0.1;
            checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %h exp 00", a, dat_o); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        wr(4'd0, 8'h20); wr(4'd6, 8'h20); wr(4'd8, 8'h40);
        irq_in = 16'h2000; tick();
        irq_in = 16'h0000;
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL basic_irqn1 got %b exp 1", irq_n); end
        tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL basic_irqn2 got %b exp 0", irq_n); end
        iack = 1'b1; tick();
        checks++; if (vec_valid !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", vec_valid); end
        checks++; if (vec_o !== 8'h4D) begin errors++; $display("FAIL basic_vec got %h exp 4d", vec_o); end
        addr = 4'd2; #1;
        checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL basic_ipra got %h exp 00", dat_o); end
        tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL basic_irqn3 got %b exp 1", irq_n); end
        checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL basic_vld2 got %b exp 0", vec_valid); end
        iack = 1'b1; tick();
        checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL ack_idle_vld got %b exp 0", vec_valid); end
        checks++; if (vec_o !== 8'h4D) begin errors++; $display("FAIL ack_idle_vec got %h exp 4d", vec_o); end
    endtask

    task automatic test_priority();
        apply_reset();
        wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF); wr(4'd8, 8'h40);
        irq_in = 16'h2010; tick();
        irq_in = 16'h0000; tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL prio_irqn got %b exp 0", irq_n); end
        iack = 1'b1; tick();
        checks++; if (vec_o !== 8'h4D) begin errors++; $display("FAIL prio_vec1 got %h exp 4d", vec_o); end
        iack = 1'b1; tick();
        checks++; if (vec_o !== 8'h44 || vec_valid !== 1'b1) begin errors++; $display("FAIL prio_vec2 got %h/%b exp 44/1", vec_o, vec_valid); end
        tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL prio_idle got %b exp 1", irq_n); end
    endtask

    task automatic test_smode();
        apply_reset();
        wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF); wr(4'd8, 8'h48);
        irq_in = 16'h0020; tick();
        irq_in = 16'h0000; tick();
        iack = 1'b1; tick();
        checks++; if (vec_o !== 8'h45) begin errors++; $display("FAIL smode_vec5 got %h exp 45", vec_o); end
`ifdef MFP_IRQ_SEI_EN
        addr = 4'd5; #1;
        checks++; if (dat_o !== 8'h20) begin errors++; $display("FAIL smode_isrb got %h exp 20", dat_o); end
        tick();
        irq_in = 16'h0004; tick();
        irq_in = 16'h0000; tick(); tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL smode_block got %b exp 1", irq_n); end
        irq_in = 16'h0200; tick();
        irq_in = 16'h0000; tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL smode_ch9 got %b exp 0", irq_n); end
        iack = 1'b1; tick();
        checks++; if (vec_o !== 8'h49) begin errors++; $display("FAIL smode_vec9 got %h exp 49", vec_o); end
        addr = 4'd4; #1;
        checks++; if (dat_o !== 8'h02) begin errors++; $display("FAIL smode_isra got %h exp 02", dat_o); end
        wr(4'd4, 8'hFD);
        wr(4'd5, 8'hDF);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL smode_still got %b exp 1", irq_n); end
        tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL smode_release got %b exp 0", irq_n); end
        iack = 1'b1; tick();
        checks++; if (vec_o !== 8'h42) begin errors++; $display("FAIL smode_vec2 got %h exp 42", vec_o); end
`else
        addr = 4'd8; #1;
        checks++; if (dat_o !== 8'h40) begin errors++; $display("FAIL nosei_vr got %h exp 40", dat_o); end
        addr = 4'd5; #1;
        checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL nosei_isrb got %h exp 00", dat_o); end
        tick();
        irq_in = 16'h0004; tick();
        irq_in = 16'h0000; tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL nosei_ch2 got %b exp 0", irq_n); end
`endif
    endtask

    task automatic test_mask();
        apply_reset();
        wr(4'd1, 8'h01);
        irq_in = 16'h0001; tick();
        irq_in = 16'h0000; tick(); tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL mask_irqn got %b exp 1", irq_n); end
        addr = 4'd3; #1;
        checks++; if (dat_o !== 8'h01) begin errors++; $display("FAIL mask_iprb got %h exp 01", dat_o); end
        wr(4'd7, 8'h01);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL mask_wr got %b exp 1", irq_n); end
        tick();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL mask_open got %b exp 0", irq_n); end
    endtask

    task automatic test_collision();
        apply_reset();
        wr(4'd0, 8'h80); wr(4'd6, 8'h80);
        irq_in = 16'h8000; tick();
        irq_in = 16'h0000; tick();
        irq_in = 16'h8000; wr(4'd2, 8'h00);
        irq_in = 16'h0000;
        addr = 4'd2; #1;
        checks++; if (dat_o !== 8'h80) begin errors++; $display("FAIL coll_ipr_set got %h exp 80", dat_o); end
        wr(4'd0, 8'h00);
        addr = 4'd2; #1;
        checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL coll_ier_clr got %h exp 00", dat_o); end
        wr(4'd0, 8'h80);
        irq_in = 16'h8000; wr(4'd0, 8'h00);
        irq_in = 16'h0000;
        addr = 4'd2; #1;
        checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL coll_ier_edge got %h exp 00", dat_o); end
        wr(4'd0, 8'h80);
        irq_in = 16'h8000; tick();
        irq_in = 16'h0000; tick();
        irq_in = 16'h8000; iack = 1'b1; tick();
        irq_in = 16'h0000;
        checks++; if (vec_valid !== 1'b1 || vec_o !== 8'h0F) begin errors++; $display("FAIL coll_ack got %h/%b exp 0f/1", vec_o, vec_valid); end
        addr = 4'd2; #1;
        checks++; if (dat_o !== 8'h80) begin errors++; $display("FAIL coll_ack_ipr got %h exp 80", dat_o); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF); wr(4'd8, 8'h48);
        irq_in = 16'h0220; tick();
        irq_in = 16'h0000; tick();
        iack = 1'b1; tick();
        checks++; if (irq_n !== 1'b0 || vec_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %b/%b exp 0/1", irq_n, vec_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL arst_irqn got %b exp 1", irq_n); end
        checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL arst_vld got %b exp 0", vec_valid); end
        checks++; if (vec_o !== 8'h00) begin errors++; $display("FAIL arst_vec got %h exp 00", vec_o); end
        for (int a = 0; a < 9; a++) begin
            addr = 4'(a); #0.1;
            checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL arst_reg%0d got %h exp 00", a, dat_o); end
        end
        model_reset();
        rst_n = 1'b1;
        tick();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL arst_after got %b exp 1", irq_n); end
    endtask

    task automatic test_random();
        apply_reset();
        irq_in = 16'h0000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(1, 0) == 1) irq_in = irq_in ^ (16'($urandom) & 16'($urandom));
            we    = ($urandom_range(3, 0) == 0);
            addr  = 4'($urandom_range(11, 0));
            dat_i = 8'($urandom);
            iack  = ($urandom_range(2, 0) == 0);
            #1;
            checks++; if (dat_o !== m_read(addr)) begin errors++; $display("FAIL rnd_dato cyc %0d addr %0d got %h exp %h", n, addr, dat_o, m_read(addr)); end
            tick();
            checks++; if (irq_n !== m_irqn) begin errors++; $display("FAIL rnd_irqn cyc %0d got %b exp %b", n, irq_n, m_irqn); end
            checks++; if (vec_valid !== m_vld) begin errors++; $display("FAIL rnd_vld cyc %0d got %b exp %b", n, vec_valid, m_vld); end
            checks++; if (vec_o !== m_vec) begin errors++; $display("FAIL rnd_vec cyc %0d got %h exp %h", n, vec_o, m_vec); end
        end
        irq_in = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_smode();
        test_mask();
        test_collision();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
